alu: RTL and testbench

- Single-lane integer ALU for the Warp compute datapath, one instance per lane.
- Executes ADD, MUL, FMA, MAX and RELU on signed two's-complement 32-bit operands.
- Result and overflow flag are combinational from opcode and operands, valid well within one clock period.
- The clock/reset domain only generates the ready status.

---
 rtl/warp_pkg.sv | 25 ++
 rtl/alu_mul_ovf.sv | 34 +++
 rtl/alu.sv | 139 +++++++++++++
 tb/tb_alu.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/warp_pkg.sv
// -----------------------------------------------------------------------------
// warp_pkg
// Shared definitions for the Warp compute datapath lane ALU.
//   alu_opcode_e : 3-bit operation select (ADD, MUL, FMA, MAX, RELU)
//   DATA_WIDTH   : lane data width
//   MAX_INT      : largest signed DATA_WIDTH value
//   MIN_INT      : smallest signed DATA_WIDTH value
// No ports (package).
// -----------------------------------------------------------------------------
package warp_pkg;

    localparam int DATA_WIDTH = 32;

    localparam logic [DATA_WIDTH-1:0] MAX_INT = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] MIN_INT = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_MUL  = 3'd1,
        OP_FMA  = 3'd2,
        OP_MAX  = 3'd3,
        OP_RELU = 3'd4
    } alu_opcode_e;

endpackage

// File: rtl/alu_mul_ovf.sv
// -----------------------------------------------------------------------------
// alu_mul_ovf
// Signed WIDTH x WIDTH multiplier returning the truncated product and a
// signed-overflow flag. Shared by the MUL and FMA paths of the lane ALU.
// Ports:
//   a, b     : signed operands (WIDTH)
//   product  : low WIDTH bits of the full 2*WIDTH product
//   overflow : 1 when the full product does not fit in WIDTH signed bits
// -----------------------------------------------------------------------------
module alu_mul_ovf #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] product,
    output logic             overflow
);

    logic signed [2*WIDTH-1:0] a_ext;
    logic signed [2*WIDTH-1:0] b_ext;
    logic signed [2*WIDTH-1:0] full;

    // Sign-extend to 2*WIDTH first so the product is exact.
    assign a_ext = {{WIDTH{a[WIDTH-1]}}, a};
    assign b_ext = {{WIDTH{b[WIDTH-1]}}, b};
    assign full  = a_ext * b_ext;

    assign product = full[WIDTH-1:0];

    // The product fits only if the upper half is a pure sign extension
    // of the truncated result's sign bit.
    assign overflow = (full[2*WIDTH-1:WIDTH] != {WIDTH{full[WIDTH-1]}});

endmodule

// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu
// Single-lane signed integer ALU for the Warp compute datapath.
// Operations: ADD, MUL, FMA (operand1*operand2 + operand3), MAX, RELU.
// result/overflow are combinational from opcode and operands; the clocked
// logic only produces the ready status.
//
// Configuration macro:
//   ALU_SATURATE_EN : when defined, overflowing ADD/MUL/FMA results clamp to
//                     MAX_INT/MIN_INT instead of wrapping (overflow still set).
//
// Ports:
//   clk      : system clock, rising edge
//   rst      : asynchronous active-high reset
//   opcode   : operation select (alu_opcode_e)
//   operand1 : signed operand A (sole RELU input)
//   operand2 : signed operand B
//   operand3 : signed addend (FMA only)
//   result   : operation result (0 while rst=1)
//   overflow : signed overflow of the selected operation (0 while rst=1)
//   ready    : ALU accepts and evaluates operands
//
// Status semantics: there is no valid/ready handshake. ready is a pure status
// flop: cleared asynchronously by rst, set on the first rising clk edge after
// rst deasserts and held high. While ready=1 the outputs track the inputs
// combinationally in the same cycle; nothing is stored or pipelined.
// -----------------------------------------------------------------------------
module alu
    import warp_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  alu_opcode_e       opcode,
    input  logic [WIDTH-1:0]  operand1,
    input  logic [WIDTH-1:0]  operand2,
    input  logic [WIDTH-1:0]  operand3,
    output logic [WIDTH-1:0]  result,
    output logic              overflow,
    output logic              ready
);

`ifdef ALU_SATURATE_EN
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    // Clamp toward the true result's sign: negative -> MIN, else MAX.
    function automatic logic [WIDTH-1:0] clamp(input logic negative);
        return negative ? SAT_MIN : SAT_MAX;
    endfunction
`endif

    // Signed add overflow: same-sign inputs producing an opposite-sign sum.
    function automatic logic add_ovf(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [WIDTH-1:0] s
    );
        return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    endfunction

    logic [WIDTH-1:0] mul_lo;
    logic             mul_ovf;
    logic [WIDTH-1:0] add_sum;
    logic [WIDTH-1:0] fma_sum;
    logic             fma_add_ovf;
    logic [WIDTH-1:0] alu_result;
    logic             alu_ovf;

    alu_mul_ovf #(
        .WIDTH (WIDTH)
    ) u_mul (
        .a        (operand1),
        .b        (operand2),
        .product  (mul_lo),
        .overflow (mul_ovf)
    );

    assign add_sum     = operand1 + operand2;
    // FMA adds the truncated product, so its add overflow is judged on mul_lo.
    assign fma_sum     = mul_lo + operand3;
    assign fma_add_ovf = add_ovf(mul_lo, operand3, fma_sum);

    always_comb begin
        alu_result = '0;
        alu_ovf    = 1'b0;
        case (opcode)
            OP_ADD: begin
                alu_result = add_sum;
                alu_ovf    = add_ovf(operand1, operand2, add_sum);
`ifdef ALU_SATURATE_EN
                if (alu_ovf) alu_result = clamp(operand1[WIDTH-1]);
`endif
            end
            OP_MUL: begin
                alu_result = mul_lo;
                alu_ovf    = mul_ovf;
`ifdef ALU_SATURATE_EN
                if (mul_ovf) alu_result = clamp(operand1[WIDTH-1] ^ operand2[WIDTH-1]);
`endif
            end
            OP_FMA: begin
                alu_result = fma_sum;
                alu_ovf    = mul_ovf | fma_add_ovf;
`ifdef ALU_SATURATE_EN
                // A product overflow dominates: the addend cannot rescue it.
                if (mul_ovf)
                    alu_result = clamp(operand1[WIDTH-1] ^ operand2[WIDTH-1]);
                else if (fma_add_ovf)
                    alu_result = clamp(operand3[WIDTH-1]);
`endif
            end
            OP_MAX: begin
                alu_result = ($signed(operand1) >= $signed(operand2)) ? operand1 : operand2;
            end
            OP_RELU: begin
                alu_result = operand1[WIDTH-1] ? '0 : operand1;
            end
            default: begin
                alu_result = '0;
                alu_ovf    = 1'b0;
            end
        endcase
    end

    // Reset forces the combinational outputs low, independent of the clock.
    assign result   = rst ? '0 : alu_result;
    assign overflow = rst ? 1'b0 : alu_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready <= 1'b0;
        end else begin
            ready <= 1'b1;
        end
    end

endmodule

// File: tb/tb_alu.sv
// -----------------------------------------------------------------------------
// tb_alu
// Scoreboarded bench for the lane ALU. The driver applies operands just after
// a rising edge and queues the expected {overflow, result}; the monitor pops
// and compares on the following falling edge. Expectations come from a
// reference model that works on wide signed integers and range checks.
// Build with +define+ALU_SATURATE_EN to exercise the clamping variant.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu;
    import warp_pkg::*;

    localparam int W  = 32;
    localparam int EW = W + 1;
    localparam longint MAXI = 64'sd2147483647;
    localparam longint MINI = -64'sd2147483648;

    logic          clk;
    logic          rst;
    alu_opcode_e   opcode;
    logic [W-1:0]  operand1;
    logic [W-1:0]  operand2;
    logic [W-1:0]  operand3;
    logic [W-1:0]  result;
    logic          overflow;
    logic          ready;

    logic          stim_valid;
    logic [EW-1:0] exp_q[$];
    int            checks;
    int            errors;

    alu #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .opcode   (opcode),
        .operand1 (operand1),
        .operand2 (operand2),
        .operand3 (operand3),
        .result   (result),
        .overflow (overflow),
        .ready    (ready)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    // ---------------- reference model ----------------
    function automatic bit out_of_range(input longint v);
        return (v > MAXI) || (v < MINI);
    endfunction

    function automatic logic [W-1:0] sat_val(input bit negative);
        return negative ? 32'h8000_0000 : 32'h7FFF_FFFF;
    endfunction

    function automatic logic [EW-1:0] ref_model(
        input alu_opcode_e op,
        input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c
    );
        longint sa, sb, sc, s, p, pl;
        logic [W-1:0] r;
        bit o, mo;
        sa = longint'(int'(a));
        sb = longint'(int'(b));
        sc = longint'(int'(c));
        r = '0;
        o = 1'b0;
        case (op)
            OP_ADD: begin
                s = sa + sb;
                o = out_of_range(s);
                r = s[W-1:0];
`ifdef ALU_SATURATE_EN
                if (o) r = sat_val(sa < 0);
`endif
            end
            OP_MUL: begin
                p = sa * sb;
                o = out_of_range(p);
                r = p[W-1:0];
`ifdef ALU_SATURATE_EN
                if (o) r = sat_val((sa < 0) != (sb < 0));
`endif
            end
            OP_FMA: begin
                p  = sa * sb;
                mo = out_of_range(p);
                pl = longint'(int'(p[W-1:0]));
                s  = pl + sc;
                o  = mo || out_of_range(s);
                r  = s[W-1:0];
`ifdef ALU_SATURATE_EN
                if (mo) r = sat_val((sa < 0) != (sb < 0));
                else if (o) r = sat_val(sc < 0);
`endif
            end
            OP_MAX:  r = (sa >= sb) ? a : b;
            OP_RELU: r = (sa < 0) ? '0 : a;
            default: begin
                r = '0;
                o = 1'b0;
            end
        endcase
        return {o, r};
    endfunction

    // ---------------- driver ----------------
    task automatic drive(
        input alu_opcode_e op,
        input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
        input logic [EW-1:0] expv
    );
        @(posedge clk);
        #1;
        opcode     = op;
        operand1   = a;
        operand2   = b;
        operand3   = c;
        stim_valid = 1'b1;
        exp_q.push_back(expv);
    endtask

    task automatic drive_model(
        input alu_opcode_e op,
        input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c
    );
        drive(op, a, b, c, ref_model(op, a, b, c));
    endtask

    // Test-plan vectors: literal wrap-mode expectations; the clamping build
    // takes its expectations from the model instead.
    task automatic directed(
        input alu_opcode_e op,
        input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
        input logic [W-1:0] r, input logic o
    );
`ifdef ALU_SATURATE_EN
        drive_model(op, a, b, c);
`else
        drive(op, a, b, c, {o, r});
`endif
    endtask

    task automatic go_idle();
        @(posedge clk);
        #1;
        stim_valid = 1'b0;
    endtask

    task automatic check_bit(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", name, act, req);
        end
    endtask

    task automatic check_word(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, req);
        end
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 6))
            0: return 32'h7FFF_FFFF;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return W'($urandom_range(0, 15));
            4: return W'($urandom_range(0, 65535)) << $urandom_range(0, 16);
            default: return $urandom;
        endcase
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (stim_valid) begin
            logic [EW-1:0] e;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_underflow: output with no expectation at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                checks++;
                if ({overflow, result} !== e) begin
                    errors++;
                    $display("FAIL op%0d a=%08h b=%08h c=%08h: got res=%08h ovf=%0b expected res=%08h ovf=%0b",
                             opcode, operand1, operand2, operand3, result, overflow, e[W-1:0], e[W]);
                end
                check_bit("ready_during_op", ready, 1'b1);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        checks     = 0;
        errors     = 0;
        stim_valid = 1'b0;
        rst        = 1'b1;
        opcode     = OP_ADD;
        operand1   = 32'h7FFF_FFFF;
        operand2   = 32'h0000_0001;
        operand3   = 32'h0;

        // Reset held for 100 ns with operands that would otherwise overflow.
        #50;
        check_bit("reset_ready", ready, 1'b0);
        check_word("reset_result", result, 32'h0);
        check_bit("reset_overflow", overflow, 1'b0);
        #50;
        rst = 1'b0;
        #1;
        check_bit("ready_before_edge", ready, 1'b0);
        @(posedge clk);
        #1;
        check_bit("ready_after_edge", ready, 1'b1);

        // ADD
        directed(OP_ADD, 32'h7FFF_FFFF, 32'h1, 32'h0, 32'h8000_0000, 1'b1);
        directed(OP_ADD, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h7FFF_FFFF, 1'b1);
        directed(OP_ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 1'b0);
        directed(OP_ADD, 32'h8000_0000, 32'h8000_0000, 32'h0, 32'h0, 1'b1);
        // MUL
        directed(OP_MUL, 32'h0001_0000, 32'h0001_0000, 32'h0, 32'h0, 1'b1);
        directed(OP_MUL, 32'h7FFF_FFFF, 32'h2, 32'h0, 32'hFFFF_FFFE, 1'b1);
        directed(OP_MUL, 32'h5, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFB, 1'b0);
        directed(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 1'b0);
        directed(OP_MUL, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b1);
        directed(OP_MUL, 32'h0, 32'h8000_0000, 32'h0, 32'h0, 1'b0);
        // FMA
        directed(OP_FMA, 32'h2, 32'h3, 32'h4, 32'hA, 1'b0);
        directed(OP_FMA, 32'hFFFF_FFFF, 32'h2, 32'h5, 32'h3, 1'b0);
        directed(OP_FMA, 32'h7FFF_FFFF, 32'h1, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 1'b1);
        directed(OP_FMA, 32'h0001_0000, 32'h0001_0000, 32'h0, 32'h0, 1'b1);
        // MAX
        directed(OP_MAX, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0, 32'hFFFF_FFFF, 1'b0);
        directed(OP_MAX, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0, 32'h7FFF_FFFF, 1'b0);
        directed(OP_MAX, 32'h5, 32'h5, 32'h0, 32'h5, 1'b0);
        // RELU (operand2/3 deliberately non-zero: they must be ignored)
        directed(OP_RELU, 32'h8000_0000, 32'h1234_5678, 32'h9, 32'h0, 1'b0);
        directed(OP_RELU, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h9, 32'h0, 1'b0);
        directed(OP_RELU, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h9, 32'h7FFF_FFFF, 1'b0);
        directed(OP_RELU, 32'h0, 32'h5, 32'h9, 32'h0, 1'b0);
        // Unused encodings
        directed(alu_opcode_e'(3'd5), 32'h7FFF_FFFF, 32'h1, 32'h1, 32'h0, 1'b0);
        directed(alu_opcode_e'(3'd7), 32'hFFFF_FFFF, 32'h3, 32'h2, 32'h0, 1'b0);

        // Asynchronous reset in mid-operation, away from any clock edge.
        go_idle();
        opcode   = OP_ADD;
        operand1 = 32'h7FFF_FFFF;
        operand2 = 32'h1;
        #2;
        rst = 1'b1;
        #1;
        check_bit("async_rst_ready", ready, 1'b0);
        check_word("async_rst_result", result, 32'h0);
        check_bit("async_rst_overflow", overflow, 1'b0);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_bit("ready_after_rerelease", ready, 1'b1);

        // Randomized traffic against the model.
        for (int i = 0; i < 300; i++) begin
            drive_model(alu_opcode_e'(3'($urandom_range(0, 7))),
                        pick_operand(), pick_operand(), pick_operand());
        end
        go_idle();
        repeat (2) @(posedge clk);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
